// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a pointer-addressed, auto-incrementing
// byte register file. There is no clock stretching. SDA is only ever pulled
// low; the pull is driven through sda_dir_o.
//
// Ports:
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   scl_i, sda_i        raw bus pin levels
//   scl_o, scl_dir_o    constant 0 (SCL is never driven)
//   sda_o               constant 0 (open-drain pull-low value)
//   sda_dir_o           1 = pull SDA low, 0 = release
//   rd_addr_i/rd_data_o local combinational read port of the register file
//   wr_vld_o/wr_addr_o/wr_data_o
//                       one-cycle report of each byte written over I2C
//   busy_o              high from address match until STOP or a
//                       non-matching repeated START
module i2c_target_regs #(
    parameter logic [6:0]  SLV_ADDR = 7'h50,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              scl_o,
    output logic              scl_dir_o,
    output logic              sda_o,
    output logic              sda_dir_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic              wr_vld_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              busy_o
);

    localparam int unsigned       NREG    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_PTR,
        S_WR_DATA, S_RD_BYTE, S_RD_ACK, S_HOLD
    } state_t;

    state_t            state, state_nx;
    logic [2:0]        scl_sync, sda_sync;
    logic              scl_cur, scl_prev, sda_cur, sda_prev;
    logic              start_det, stop_det, scl_rise, scl_fall;
    logic [7:0]        shift, rx_byte;
    logic [3:0]        bit_cnt;
    logic              rw;
    logic              addr_match;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        mem [NREG];

    assign scl_o     = 1'b0;
    assign scl_dir_o = 1'b0;
    assign sda_o     = 1'b0;
    assign rd_data_o = mem[rd_addr_i];

    // Two synchronizer stages plus one history stage for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_i};
            sda_sync <= {sda_sync[1:0], sda_i};
        end
    end

    assign scl_cur    = scl_sync[1];
    assign scl_prev   = scl_sync[2];
    assign sda_cur    = sda_sync[1];
    assign sda_prev   = sda_sync[2];
    assign start_det  = scl_cur & scl_prev & sda_prev & ~sda_cur;
    assign stop_det   = scl_cur & scl_prev & ~sda_prev & sda_cur;
    assign scl_rise   = scl_cur & ~scl_prev;
    assign scl_fall   = ~scl_cur & scl_prev;
    assign rx_byte    = {shift[6:0], sda_cur};
    assign addr_match = (rx_byte[7:1] == SLV_ADDR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start_det) begin
            state_nx = S_ADDR;
        end else if (stop_det) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_ADDR:     if (scl_rise && bit_cnt == 4'd7)
                                state_nx = addr_match ? S_ADDR_ACK : S_HOLD;
                S_ADDR_ACK: if (scl_fall && bit_cnt == 4'd9)
                                state_nx = rw ? S_RD_BYTE : S_WR_PTR;
                S_WR_PTR:   if (scl_fall && bit_cnt == 4'd9)
                                state_nx = S_WR_DATA;
                S_RD_BYTE:  if (scl_fall && bit_cnt == 4'd8)
                                state_nx = S_RD_ACK;
                S_RD_ACK:   if (scl_rise && sda_cur)
                                state_nx = S_HOLD;
                            else if (scl_fall && bit_cnt == 4'd9)
                                state_nx = S_RD_BYTE;
                default:    ;
            endcase
        end
    end

    // bit_cnt counts SCL rising edges in the current byte; 8 means data
    // complete (ACK bit pending), 9 means ACK bit clocked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
            ptr       <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            sda_dir_o <= 1'b0;
            wr_vld_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            busy_o    <= 1'b0;
        end else begin
            wr_vld_o <= 1'b0;
            if (start_det) begin
                bit_cnt   <= '0;
                sda_dir_o <= 1'b0;
            end else if (stop_det) begin
                bit_cnt   <= '0;
                sda_dir_o <= 1'b0;
                busy_o    <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                busy_o <= addr_match;
                                rw     <= sda_cur;
                            end
                        end
                    end
                    S_ADDR_ACK, S_WR_PTR, S_WR_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt < 4'd8) shift <= rx_byte;
                            if (bit_cnt == 4'd7 && state == S_WR_PTR)
                                ptr <= rx_byte[ADDR_W-1:0];
                            if (bit_cnt == 4'd7 && state == S_WR_DATA) begin
                                mem[ptr]  <= rx_byte;
                                wr_vld_o  <= 1'b1;
                                wr_addr_o <= ptr;
                                wr_data_o <= rx_byte;
                                ptr       <= ptr + PTR_ONE;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_dir_o <= 1'b1;
                            end else if (bit_cnt == 4'd9) begin
                                bit_cnt <= '0;
                                if (state == S_ADDR_ACK && rw) begin
                                    shift     <= mem[ptr];
                                    sda_dir_o <= ~mem[ptr][7];
                                    ptr       <= ptr + PTR_ONE;
                                end else begin
                                    sda_dir_o <= 1'b0;
                                end
                            end
                        end
                    end
                    S_RD_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_dir_o <= 1'b0;
                                bit_cnt   <= '0;
                            end else begin
                                shift     <= {shift[6:0], 1'b0};
                                sda_dir_o <= ~shift[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise && !sda_cur) begin
                            bit_cnt <= 4'd9;
                        end else if (scl_fall && bit_cnt == 4'd9) begin
                            shift     <= mem[ptr];
                            sda_dir_o <= ~mem[ptr][7];
                            ptr       <= ptr + PTR_ONE;
                            bit_cnt   <= '0;
                        end
                    end
                    default: sda_dir_o <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-level I2C controller model on an open-drain bus
// driving i2c_target_regs, with a byte-array reference of the register file
// and pointer, directed cases plus randomized transactions.
`timescale 1ns/1ps
module tb_i2c_target_regs;

    localparam int unsigned ADDR_W = 4;
    localparam int          NREG   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              scl_m, sda_m;
    logic              scl_bus, sda_bus;
    logic              scl_o, scl_dir_o, sda_o, sda_dir_o;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [7:0]        rd_data_o;
    logic              wr_vld_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [7:0]        wr_data_o;
    logic              busy_o;

    assign scl_bus = scl_m;
    assign sda_bus = sda_m & ~sda_dir_o;

    always #5 clk = ~clk;

    i2c_target_regs #(.SLV_ADDR(7'h50), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_o(scl_o), .scl_dir_o(scl_dir_o), .sda_o(sda_o), .sda_dir_o(sda_dir_o),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .wr_vld_o(wr_vld_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o)
    );

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  model [NREG];
    int          mptr = 0;
    logic [11:0] wr_q [$];
    logic [11:0] exp_q [$];
    logic [7:0]  txq [$];
    logic        prev_vld = 1'b0;
    int          long_pulse = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_vld_o) wr_q.push_back({wr_addr_o, wr_data_o});
        if (wr_vld_o && prev_vld) long_pulse++;
        prev_vld = wr_vld_o;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    // One quarter of an SCL bit: 6 clk cycles, changes land on negedges.
    task automatic qw();
        repeat (6) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); sda_m = 1'b0; qw(); scl_m = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qw(); scl_m = 1'b1; qw(); sda_m = 1'b1; qw(); qw();
    endtask

    task automatic wbit(input logic b);
        sda_m = b; qw(); scl_m = 1'b1; qw(); qw(); scl_m = 1'b0; qw();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); b = sda_bus; qw(); scl_m = 1'b0; qw();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic nack);
        for (int i = 7; i >= 0; i--) rbit(d[i]);
        wbit(nack);
    endtask

    task automatic compare_events();
        chk("wr_count", wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            chk("wr_event", wr_q[i], exp_q[i]);
        wr_q.delete();
        exp_q.delete();
        chk("wr_pulse_len", long_pulse, 0);
    endtask

    task automatic compare_regs();
        for (int i = 0; i < NREG; i++) begin
            rd_addr_i = ADDR_W'(i);
            #1;
            chk("rd_data", rd_data_o, model[i]);
        end
    endtask

    // START, address byte, then txq: first byte is the pointer, rest data.
    task automatic do_write(input logic [6:0] a7, input logic with_stop);
        logic ack;
        logic match;
        match = (a7 == 7'h50);
        i2c_start();
        wbyte({a7, 1'b0}, ack);
        chk("addr_ack", ack, match ? 0 : 1);
        chk("busy_addr", busy_o, match);
        for (int k = 0; k < txq.size(); k++) begin
            wbyte(txq[k], ack);
            chk(k == 0 ? "ptr_ack" : "data_ack", ack, match ? 0 : 1);
            if (match) begin
                if (k == 0) begin
                    mptr = txq[k] % NREG;
                end else begin
                    exp_q.push_back({4'(mptr), txq[k]});
                    model[mptr] = txq[k];
                    mptr = (mptr + 1) % NREG;
                end
            end
        end
        if (with_stop) begin
            i2c_stop();
            chk("busy_stop", busy_o, 0);
        end
        compare_events();
        compare_regs();
    endtask

    // START (or repeated START), read address, n bytes, NACK on the last.
    task automatic do_read(input int n);
        logic ack;
        logic [7:0] d;
        i2c_start();
        wbyte(8'hA1, ack);
        chk("rd_addr_ack", ack, 0);
        chk("busy_rd", busy_o, 1);
        for (int k = 0; k < n; k++) begin
            rbyte(d, k == n - 1);
            chk("rd_byte", d, model[mptr]);
            mptr = (mptr + 1) % NREG;
        end
        chk("nack_release", sda_dir_o, 0);
        chk("busy_hold", busy_o, 1);
    endtask

    initial begin
        logic       b;
        logic       ack;
        logic       dir_seen;
        int         n;
        int         kind;
        logic [6:0] a7;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr_i = '0;
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_sda_dir", sda_dir_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_wr_vld", wr_vld_o, 0);
        chk("rst_wr_addr", wr_addr_o, 0);
        chk("rst_wr_data", wr_data_o, 0);
        chk("rst_scl_dir", scl_dir_o, 0);
        compare_regs();
        rst = 1'b0;
        qw();

        // Write ptr 3, data 11 22.
        txq = {8'h03, 8'h11, 8'h22};
        do_write(7'h50, 1'b1);
        // Pointer wrap 15 -> 0.
        txq = {8'h0F, 8'hAA, 8'hBB};
        do_write(7'h50, 1'b1);
        // Restore 11/22 at 3/4 for the read-back case.
        txq = {8'h03, 8'h11, 8'h22};
        do_write(7'h50, 1'b1);
        // Set ptr 3, repeated START, read two bytes, STOP.
        txq = {8'h03};
        do_write(7'h50, 1'b0);
        do_read(2);
        i2c_stop();
        chk("busy_after_read", busy_o, 0);
        // Non-matching address: nothing acknowledged, nothing written.
        txq = {8'h03, 8'h5A};
        do_write(7'h51, 1'b1);

        // START then STOP after four address bits.
        dir_seen = 1'b0;
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            wbit(i[0]);
            if (sda_dir_o) dir_seen = 1'b1;
        end
        i2c_stop();
        chk("partial_no_ack", dir_seen, 0);
        chk("partial_busy", busy_o, 0);
        compare_events();

        // Repeated START mid data byte discards the partial byte.
        i2c_start();
        wbyte(8'hA0, ack);
        chk("rs_addr_ack", ack, 0);
        wbyte(8'h09, ack);
        chk("rs_ptr_ack", ack, 0);
        mptr = 9;
        for (int i = 0; i < 4; i++) wbit(1'b1);
        txq = {8'h06, 8'h77};
        do_write(7'h50, 1'b1);

        // Reset while the target pulls SDA low for a read data bit.
        txq = {8'h07, 8'h0F};
        do_write(7'h50, 1'b1);
        txq = {8'h07};
        do_write(7'h50, 1'b0);
        i2c_start();
        wbyte(8'hA1, ack);
        chk("rst_rd_addr_ack", ack, 0);
        rbit(b);
        rbit(b);
        chk("rd_drive_low", sda_dir_o, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_sda", sda_dir_o, 0);
        chk("async_rst_busy", busy_o, 0);
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;
        mptr = 0;
        compare_regs();
        chk("async_rst_wr_addr", wr_addr_o, 0);
        chk("async_rst_wr_data", wr_data_o, 0);
        sda_m = 1'b1; scl_m = 1'b1;
        qw();
        rst = 1'b0;
        qw();
        // Pointer must restart from 0 after reset.
        do_read(2);
        i2c_stop();
        compare_events();

        // Randomized transactions.
        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(0, 2);
            n = $urandom_range(1, 4);
            txq.delete();
            txq.push_back(8'($urandom));
            if (kind == 0) begin
                for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
                do_write(7'h50, 1'b1);
            end else if (kind == 1) begin
                do_write(7'h50, 1'b0);
                do_read(n);
                i2c_stop();
                chk("busy_after_rnd_read", busy_o, 0);
            end else begin
                a7 = 7'($urandom);
                if (a7 == 7'h50) a7 = 7'h51;
                txq.push_back(8'($urandom));
                do_write(a7, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) with a small byte register file, the responder-side counterpart of the SoC's I2C controllers. It sits on an external I2C bus (or a loopback of the SoC's `i2c_if` pins in simulation), decodes START/STOP/address and serves pointer-addressed, auto-incrementing byte reads and writes. A local port gives on-chip read access and reports every I2C write. It does no clock stretching.

## Interface
- `SLV_ADDR`, default 7'h50: 7-bit target address.
- `ADDR_W`, default 4: register index width; `NREG = 2**ADDR_W` bytes.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `scl_i` in 1: raw SCL pin level.
- `sda_i` in 1: raw SDA pin level.
- `scl_o` out 1: constant 0.
- `scl_dir_o` out 1: constant 0 (SCL never driven).
- `sda_o` out 1: constant 0 (open-drain pull-low value).
- `sda_dir_o` out 1: 1 = pull SDA low, 0 = release.
- `rd_addr_i` in ADDR_W: local read index.
- `rd_data_o` out 8: `reg[rd_addr_i]`, combinational.
- `wr_vld_o` out 1: one-cycle pulse per byte written over I2C.
- `wr_addr_o` out ADDR_W: index of that write.
- `wr_data_o` out 8: data of that write.
- `busy_o` out 1: high from address match to STOP/non-matching repeated START.

## Operation
- Input conditioning: `scl_i`/`sda_i` pass through 2-flop synchronizers, then a third flop for edge detection. All decisions use synchronized values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are recognized in every state and take priority. START -> ADDR with bit counter cleared. STOP -> IDLE.
- Bits are sampled on the SCL rising edge, MSB first. SDA is changed only after an SCL falling edge.
- FSM states:
  - IDLE: SDA released.
  - ADDR: shift 8 bits. On the 8th rising edge, compare `[7:1]` with `SLV_ADDR`.
    - Match: go to ADDR_ACK; `busy_o`=1; latch R/W.
    - Mismatch: go to HOLD.
  - ADDR_ACK: pull SDA low from the falling edge after bit 8 until the falling edge after bit 9.
    - Then R/W=0 goes to WR_PTR.
    - R/W=1 goes to RD_BYTE, which loads `reg[ptr]` into the shifter and drives its MSB at that same falling edge.
  - WR_PTR: receive 8 bits; `ptr <= byte[ADDR_W-1:0]` (upper bits ignored); ACK; then WR_DATA.
  - WR_DATA: receive 8 bits, then:
    - `reg[ptr] <= byte`;
    - one-cycle `wr_vld_o` with pre-increment `ptr` as `wr_addr_o`;
    - `ptr <= ptr+1` mod NREG, wrapping NREG-1 -> 0;
    - ACK; stay in WR_DATA.
  - RD_BYTE: drive `sda_dir_o = ~shift[7]` for each of 8 bits, then release SDA for bit 9. Go to RD_ACK. `ptr` increments (wrapping) when the byte is loaded.
  - RD_ACK: sample the controller's bit 9 on the rising edge.
    - 0 (ACK): load next `reg[ptr]` on the falling edge; RD_BYTE.
    - 1 (NACK): HOLD.
  - HOLD: SDA released; wait for START or STOP.
- `ptr` persists across transactions; reset value 0. Reads never modify registers.
- Reset (async, any time, including mid-byte):
  - all registers and `ptr` = 0; FSM = IDLE; SDA released immediately;
  - `sda_dir_o` = 0, `wr_vld_o` = 0, `wr_addr_o` = 0, `wr_data_o` = 0, `busy_o` = 0;
  - `rd_data_o` = 0 for any index;
  - synchronizer flops reset to 1 (idle bus).

## Timing
- Pin-to-decision latency: 3 `clk_i` cycles.
- `sda_dir_o` changes 3 cycles after the SCL falling edge at the pin.
- Requirement: SCL high and low phases are each ≥ 6 `clk_i` periods (e.g. 400 kHz SCL needs `clk_i` ≥ 5 MHz).
- `wr_vld_o` asserts on the cycle after the 8th data-bit rising edge is detected, for exactly 1 cycle. `reg[]` is updated on the same edge, so `rd_data_o` reflects the new value on the following cycle.
- Simultaneous local read and I2C write of the same index: `rd_data_o` shows the old value until the write cycle completes.
- Repeated START mid-byte: partial byte discarded, no write, no `wr_vld_o`.
- START during ADDR_ACK/WR ACK: SDA released at once.
- STOP mid-read: SDA released within 3 cycles; `ptr` keeps its incremented value.

## Test plan
- Write 0xA0, ptr 0x03, data 0x11 0x22, STOP -> ACK on all 4 bytes; `wr_vld_o` pulses with (3,0x11) then (4,0x22); `rd_addr_i`=4 gives 0x22; `busy_o` drops after STOP.
- Write ptr 0x0F, data 0xAA 0xBB -> writes (15,0xAA) then (0,0xBB); wrap verified.
- Write ptr 0x03, repeated START, read 0xA1, 2 bytes ACK then NACK, STOP -> SDA carries 0x11, 0x22; ends in HOLD, then IDLE after STOP.
- Address 0x51 write -> no ACK (SDA stays high on bit 9), `busy_o` stays 0, no `wr_vld_o`.
- Assert `rst_i` mid-data-byte while the target drives SDA low -> `sda_dir_o`=0 the same cycle; all registers read 0; next full transaction behaves normally.
- START then STOP after 4 address bits -> IDLE, no ACK, no state change.
